// File: rtl/icache_l2_arb_pkg.sv
// Shared types and default widths for the icache L2 request arbiter.
// The optional watchdog is enabled with ICACHE_L2_ARB_TIMEOUT_EN.
package icache_l2_arb_pkg;

  localparam int unsigned PaddrWDef        = 40;
  localparam int unsigned LineWDef         = 256;
  localparam int unsigned NcAlignDef       = 3;
  localparam int unsigned TimeoutCyclesDef = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_MISS = 1'b0,
    OWNER_NC   = 1'b1
  } arb_owner_t;

  // Clears the low 'lsb' bits; callers cast the result back to their address width.
  function automatic logic [63:0] align_addr(input logic [63:0] addr, input int unsigned lsb);
    return addr & ~((64'd1 << lsb) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_l2_req_arbiter_if.sv
// Requester, L2 and response signals of the icache L2 request arbiter.
// timeout_o exists only when ICACHE_L2_ARB_TIMEOUT_EN is defined.
interface icache_l2_req_arbiter_if #(
  parameter int unsigned PADDR_W = 40,
  parameter int unsigned LINE_W  = 256
);
  logic               miss_req_valid_i;
  logic [PADDR_W-1:0] miss_req_paddr_i;
  logic               miss_req_ready_o;
  logic               nc_req_valid_i;
  logic [PADDR_W-1:0] nc_req_paddr_i;
  logic               nc_req_ready_o;
  logic               flush_i;
  logic               l2_req_valid_o;
  logic [PADDR_W-1:0] l2_req_paddr_o;
  logic               l2_req_nc_o;
  logic               l2_req_ready_i;
  logic               l2_resp_valid_i;
  logic [LINE_W-1:0]  l2_resp_data_i;
  logic               miss_resp_valid_o;
  logic               nc_resp_valid_o;
  logic [LINE_W-1:0]  resp_data_o;
  logic               busy_o;
`ifdef ICACHE_L2_ARB_TIMEOUT_EN
  logic               timeout_o;
`endif

  modport slave (
`ifdef ICACHE_L2_ARB_TIMEOUT_EN
    output timeout_o,
`endif
    input  miss_req_valid_i, miss_req_paddr_i, nc_req_valid_i, nc_req_paddr_i, flush_i,
    input  l2_req_ready_i, l2_resp_valid_i, l2_resp_data_i,
    output miss_req_ready_o, nc_req_ready_o, l2_req_valid_o, l2_req_paddr_o, l2_req_nc_o,
    output miss_resp_valid_o, nc_resp_valid_o, resp_data_o, busy_o
  );

  modport master (
`ifdef ICACHE_L2_ARB_TIMEOUT_EN
    input  timeout_o,
`endif
    output miss_req_valid_i, miss_req_paddr_i, nc_req_valid_i, nc_req_paddr_i, flush_i,
    output l2_req_ready_i, l2_resp_valid_i, l2_resp_data_i,
    input  miss_req_ready_o, nc_req_ready_o, l2_req_valid_o, l2_req_paddr_o, l2_req_nc_o,
    input  miss_resp_valid_o, nc_resp_valid_o, resp_data_o, busy_o
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; req/gnt bit 0 is the miss path, bit 1 the NC path.
// last_grant only moves when update_i confirms the grant was taken.
module rr_arbiter_2
  import icache_l2_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  arb_owner_t last_grant_q, last_grant_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_grant_q == OWNER_NC) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase

    last_grant_d = last_grant_q;
    if (update_i && (gnt_o != 2'b00)) begin
      last_grant_d = gnt_o[1] ? OWNER_NC : OWNER_MISS;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= OWNER_NC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/icache_l2_req_arbiter.sv
// Shares one L2 fetch channel between icache refills and non-cacheable fetches, one in flight.
// Define ICACHE_L2_ARB_TIMEOUT_EN to add the WAIT/DRAIN watchdog and timeout_o.
module icache_l2_req_arbiter
  import icache_l2_arb_pkg::*;
#(
  parameter int unsigned PADDR_W        = PaddrWDef,
  parameter int unsigned LINE_W         = LineWDef,
  parameter int unsigned NC_ALIGN       = NcAlignDef,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef
) (
  input logic clk_i,
  input logic rst_i,
  icache_l2_req_arbiter_if.slave bus
);

  localparam int unsigned LineOffW = $clog2(LINE_W / 8);

  arb_state_t         state_q, state_d;
  arb_owner_t         owner_q, owner_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic               kill_q, kill_d;
  logic [LINE_W-1:0]  resp_data_q, resp_data_d;
  logic               miss_pulse_q, miss_pulse_d;
  logic               nc_pulse_q, nc_pulse_d;
  logic [1:0]         gnt;
  logic               accept;
  logic               kill_pend;

`ifdef ICACHE_L2_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  rr_arbiter_2 u_rr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({bus.nc_req_valid_i, bus.miss_req_valid_i}),
    .update_i (accept),
    .gnt_o    (gnt)
  );

  assign accept = (state_q == IDLE) && !rst_i && !bus.flush_i &&
                  (bus.miss_req_valid_i || bus.nc_req_valid_i);
  // A flush seen in the same cycle counts as already pending.
  assign kill_pend = kill_q || bus.flush_i;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    paddr_d      = paddr_q;
    kill_d       = kill_q;
    resp_data_d  = resp_data_q;
    miss_pulse_d = 1'b0;
    nc_pulse_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (accept) begin
          owner_d = gnt[1] ? OWNER_NC : OWNER_MISS;
          paddr_d = gnt[1] ? PADDR_W'(align_addr(64'(bus.nc_req_paddr_i), NC_ALIGN))
                           : PADDR_W'(align_addr(64'(bus.miss_req_paddr_i), LineOffW));
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.flush_i) kill_d = 1'b1;
        if (bus.l2_req_ready_i) state_d = kill_pend ? DRAIN : WAIT;
      end
      WAIT: begin
        if (bus.l2_resp_valid_i) begin
          state_d = IDLE;
          if (!kill_pend) begin
            resp_data_d  = bus.l2_resp_data_i;
            miss_pulse_d = (owner_q == OWNER_MISS);
            nc_pulse_d   = (owner_q == OWNER_NC);
          end
        end else if (kill_pend) begin
          kill_d  = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.l2_resp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef ICACHE_L2_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if ((state_q == WAIT) || (state_q == DRAIN)) begin
      if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
        cnt_d     = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_MISS;
      paddr_q      <= '0;
      kill_q       <= 1'b0;
      resp_data_q  <= '0;
      miss_pulse_q <= 1'b0;
      nc_pulse_q   <= 1'b0;
`ifdef ICACHE_L2_ARB_TIMEOUT_EN
      cnt_q        <= 16'd0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      paddr_q      <= paddr_d;
      kill_q       <= kill_d;
      resp_data_q  <= resp_data_d;
      miss_pulse_q <= miss_pulse_d;
      nc_pulse_q   <= nc_pulse_d;
`ifdef ICACHE_L2_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bus.miss_req_ready_o  = accept && gnt[0];
  assign bus.nc_req_ready_o    = accept && gnt[1];
  assign bus.l2_req_valid_o    = (state_q == SEND);
  assign bus.l2_req_paddr_o    = (state_q == SEND) ? paddr_q : '0;
  assign bus.l2_req_nc_o       = (state_q == SEND) && (owner_q == OWNER_NC);
  assign bus.miss_resp_valid_o = miss_pulse_q;
  assign bus.nc_resp_valid_o   = nc_pulse_q;
  assign bus.resp_data_o       = resp_data_q;
  assign bus.busy_o            = (state_q != IDLE);
`ifdef ICACHE_L2_ARB_TIMEOUT_EN
  assign bus.timeout_o         = timeout_q;
`endif

endmodule

// File: doc/icache_l2_req_arbiter.md
Name: icache_l2_req_arbiter

Overview:
- Shares the single L2/NoC fetch request channel between the L1 instruction cache miss path (full-line refills) and the non-cacheable fetch bypass (8-byte fetches).
- Keeps exactly one L2 request outstanding at a time.
- Chooses between the two requesters with round-robin.
- Sequences request, grant and response, and routes each response back to the requester that issued it.
- Drops responses that belong to flushed requests.

Parameters:
- PADDR_W, 40: physical address width.
- LINE_W, 256: L2 response data width in bits (one icache line).
- NC_ALIGN, 3: log2 of the non-cacheable fetch granule in bytes.
- TIMEOUT_CYCLES, 1024: watchdog limit. Used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- miss_req_valid_i  in  1  icache miss request.
- miss_req_paddr_i  in  PADDR_W  miss address.
- miss_req_ready_o  out  1  miss request accepted this cycle.
- nc_req_valid_i  in  1  non-cacheable fetch request.
- nc_req_paddr_i  in  PADDR_W  non-cacheable address.
- nc_req_ready_o  out  1  non-cacheable request accepted this cycle.
- flush_i  in  1  kill any in-flight fetch (inval_fetch or invalidate_icache).
- l2_req_valid_o  out  1  request to L2.
- l2_req_paddr_o  out  PADDR_W  aligned request address.
- l2_req_nc_o  out  1  1 = non-cacheable request, 0 = line refill.
- l2_req_ready_i  in  1  L2 accepts the request.
- l2_resp_valid_i  in  1  L2 response (grant) valid.
- l2_resp_data_i  in  LINE_W  response data.
- miss_resp_valid_o  out  1  one-cycle pulse: response for the miss path.
- nc_resp_valid_o  out  1  one-cycle pulse: response for the non-cacheable path.
- resp_data_o  out  LINE_W  registered copy of l2_resp_data_i.
- busy_o  out  1  FSM is not in IDLE.

Behaviour:
- Reset:
  - FSM goes to IDLE; every output is 0.
  - last_grant is reset to NC, so the miss path wins the first tie.
  - All reset behaviour is synchronous on the rising clk_i edge. Asserting reset mid-transaction abandons it; a later stray l2_resp_valid_i seen in IDLE is ignored.
- FSM states: IDLE, SEND, WAIT, DRAIN.
- IDLE:
  - When flush_i=0 and at least one request is valid, assert the winner's ready (combinational) and capture owner, nc flag and aligned address.
  - Tie: grant the requester that is not last_grant, then update last_grant.
  - Next state is SEND.
  - flush_i=1 blocks acceptance in that cycle.
- Address alignment:
  - Miss: low log2(LINE_W/8) bits cleared.
  - Non-cacheable: low NC_ALIGN bits cleared.
- SEND:
  - l2_req_valid_o=1, with address and nc flag held stable until l2_req_ready_i.
  - A request is never withdrawn.
  - On handshake, go to WAIT, or to DRAIN if a kill is pending.
- WAIT:
  - On l2_resp_valid_i, register the data into resp_data_o.
  - Next cycle, pulse the owner's resp_valid for exactly one cycle; return to IDLE in that same transition.
  - Acceptance latency: earliest new acceptance is the IDLE cycle in which the response pulse is visible.
- Kill:
  - flush_i in SEND or WAIT sets a kill flag.
  - In WAIT, the FSM goes to DRAIN next cycle, unless the response arrives in that same cycle; then the response is suppressed and the FSM goes to IDLE.
- DRAIN:
  - Wait for l2_resp_valid_i.
  - Suppress both resp_valid outputs; resp_data_o is not updated.
  - Then go to IDLE.
- Responses outside WAIT/DRAIN are ignored.
- flush_i while already in DRAIN has no further effect.
- ready outputs are 0 in every state except IDLE.

Optional Feature:
- Macro: ICACHE_L2_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in WAIT/DRAIN and clears on entry.
  - Reaching TIMEOUT_CYCLES forces IDLE, drops the transaction (no resp pulse) and pulses output timeout_o for one cycle.
  - Reset value of timeout_o is 0.
- When undefined: no counter, no timeout_o port, and WAIT/DRAIN wait indefinitely.

Decomposition:
- Shared package icache_l2_arb_pkg:
  - arb_state_t enum (IDLE, SEND, WAIT, DRAIN).
  - arb_owner_t enum (OWNER_MISS, OWNER_NC).
  - Constants for the default widths and the NC alignment.
- Sub-module rr_arbiter_2: two-requester round-robin with last_grant register and update-enable input.

Test Plan:
- Reset, then miss_req paddr 0x80001234 only:
  - miss_req_ready_o=1 in the acceptance cycle.
  - l2_req_paddr_o=0x80001220, l2_req_nc_o=0.
  - L2 ready after 2 cycles and response data 0xA5… 3 cycles later → miss_resp_valid_o one-cycle pulse with resp_data_o=0xA5…; nc_resp_valid_o stays 0.
- Both requests valid after reset, repeated 4 times → grant order MISS, NC, MISS, NC. Non-cacheable address 0x00010007 → l2_req_paddr_o=0x00010000, l2_req_nc_o=1.
- flush_i for one cycle during WAIT (NC owner) → DRAIN; the response is consumed with no resp pulse; busy_o falls 1 cycle after the response.
- flush_i during SEND with l2_req_ready_i low → l2_req_valid_o held until ready; then DRAIN; response suppressed.
- flush_i in the same cycle as l2_resp_valid_i in WAIT → no pulse, IDLE next cycle. Stray response in IDLE → ignored.
- rst_i asserted while in WAIT → all outputs 0 next cycle. With ICACHE_L2_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response → timeout_o pulses, then IDLE.
